do_pixel_filter: RTL
====================

// Module: do_pixel_filter
// PURPOSE
//  Parametrised in-place frame-buffer filter, successor to the single-mode B/W pass.
//  - Streams every pixel of frame buffer 2: read, transform, write back to the same address.
//  - Pipelined at one pixel per clock.
//  - Mode-selectable: grey average, grey luma, binary threshold, invert.
//  - Sits between the capture buffer and the VGA reader; re-armable without reset.
// PARAMETERS
//  CH_W        4      bits per colour channel; pixel = 3*CH_W, packed {R,G,B}
//  ADDR_W      17     buffer address width
//  NUM_PIXELS  76800  pixels per frame (320x240); must be <= 2**ADDR_W
//  RD_LAT      1      buffer read latency in clocks (1..3)
// PORTS
//  clk_i          in   1         system clock (25 MHz)
//  rst_i          in   1         asynchronous reset, active-high
//  enable_filter  in   1         start request (level); sampled in IDLE only
//  mode_i         in   2         00 avg grey, 01 luma grey, 10 threshold, 11 invert
//  thresh_i       in   CH_W      threshold for mode 10
//  busy_o         out  1         high in RUN and DRAIN
//  led_done       out  1         high in DONE
//  rdaddr_buf2    out  ADDR_W    read address
//  din_buf2       in   3*CH_W    read data, valid RD_LAT clocks after address
//  wraddr_buf2    out  ADDR_W    write address
//  dout_buf2      out  3*CH_W    write data
//  we_buf2        out  1         write enable
// BEHAVIOUR
//  Reset (async): state=IDLE; all outputs 0; pipeline valid bits cleared. Applies mid-frame
//  immediately; the partial frame is left as-is and no further write is issued.
//  FSM:
//  - IDLE->RUN when enable_filter=1. mode_i and thresh_i are latched on this edge;
//    later changes are ignored until the next start.
//  - RUN: rdaddr_buf2 = 0,1,...,NUM_PIXELS-1, one per clock.
//    RUN->DRAIN after address NUM_PIXELS-1 has been issued.
//  - DRAIN: no new reads; the pipeline flushes. DRAIN->DONE on the cycle after the last write.
//  - DONE: led_done=1; DONE->IDLE when enable_filter=0. A held enable does not retrigger.
//  - enable_filter is ignored in RUN, DRAIN and DONE.
//  Timing (cycle 0 = first RUN cycle, rdaddr=0):
//  - Address k is read at cycle k.
//  - Result is registered at cycle k+RD_LAT+1 with we_buf2=1, wraddr_buf2=k.
//  - we_buf2 is high for exactly NUM_PIXELS consecutive clocks.
//  - led_done rises at cycle NUM_PIXELS+RD_LAT+1.
//  - In-place hazard: write address always lags read address by RD_LAT+1, so no pixel
//    is read after it has been written.
//  Arithmetic (all results floor, unsigned):
//  - 00: s = R+G+B (CH_W+2 bits); y = s/3 (exact, no truncation before divide);
//    out = {y,y,y}.
//  - 01: y = (5R + 9G + 2B) >> 4 (CH_W+4-bit intermediate); out = {y,y,y}.
//  - 10: y = avg as in 00; out = all ones if y >= thresh_i, else all zeros.
//  - 11: out = {~R,~G,~B}.
//  - y never exceeds 2**CH_W-1; no saturation logic required.
//  Boundaries:
//  - NUM_PIXELS=1 works: a single write, then DONE.
//  - Counters must not wrap beyond NUM_PIXELS-1.
//  - rdaddr_buf2 and wraddr_buf2 hold their last values in DRAIN and DONE;
//    both return to 0 on start.
// TESTING
//  1 mode 00, every pixel 12'hF30 -> every write 12'h666; we_buf2 count = 76800.
//  2 mode 01, pixel 12'hF00 -> 12'h444; pixel 12'hFFF -> 12'hFFF.
//  3 mode 10, thresh_i=8: 12'h777 -> 12'h000; 12'h888 -> 12'hFFF; thresh_i changed
//    mid-frame -> no effect.
//  4 mode 11, pixel 12'h123 -> 12'hEDC; wraddr_buf2 = rdaddr_buf2 - 2 (RD_LAT=1)
//    throughout RUN.
//  5 rst_i pulsed at pixel 1000 -> we_buf2=0 same cycle, state IDLE; restart completes
//    the full frame.
//  6 RD_LAT=2, NUM_PIXELS=16: led_done rises at cycle 19; enable held high in DONE ->
//    no second pass.

Source files
------------

// File: rtl/do_pixel_filter.sv
// do_pixel_filter
//   In-place frame-buffer filter. Streams every pixel of buffer 2 at one
//   pixel per clock: read, transform by the selected mode, and write back to
//   the same address. Mode and threshold are captured at start so the whole
//   frame is processed consistently. Re-armable without reset.
module do_pixel_filter #(
   parameter int CH_W       = 4,
   parameter int ADDR_W     = 17,
   parameter int NUM_PIXELS = 76800,
   parameter int RD_LAT     = 1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                enable_filter,
   input  logic [1:0]          mode_i,
   input  logic [CH_W-1:0]     thresh_i,
   output logic                busy_o,
   output logic                led_done,
   output logic [ADDR_W-1:0]   rdaddr_buf2,
   input  logic [3*CH_W-1:0]   din_buf2,
   output logic [ADDR_W-1:0]   wraddr_buf2,
   output logic [3*CH_W-1:0]   dout_buf2,
   output logic                we_buf2
);

   localparam int PIX_W = 3 * CH_W;
   localparam int SUM_W = CH_W + 2;
   localparam int LUM_W = CH_W + 4;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   // Per-pixel transform. Averages divide the full-width sum so no precision
   // is lost before the divide; the luma weights sum to 16 so y never overflows.
   function automatic logic [PIX_W-1:0] filter_pixel(
      input logic [1:0]       mode,
      input logic [CH_W-1:0]  thr,
      input logic [PIX_W-1:0] pix
   );
      logic [CH_W-1:0]  r_v;
      logic [CH_W-1:0]  g_v;
      logic [CH_W-1:0]  b_v;
      logic [SUM_W-1:0] sum_v;
      logic [CH_W-1:0]  avg_v;
      logic [LUM_W-1:0] wsum_v;
      logic [CH_W-1:0]  luma_v;
      logic [PIX_W-1:0] res_v;
      r_v    = pix[PIX_W-1 -: CH_W];
      g_v    = pix[2*CH_W-1 -: CH_W];
      b_v    = pix[CH_W-1:0];
      sum_v  = SUM_W'(r_v) + SUM_W'(g_v) + SUM_W'(b_v);
      avg_v  = CH_W'(sum_v / SUM_W'(3));
      wsum_v = LUM_W'(5) * LUM_W'(r_v) + LUM_W'(9) * LUM_W'(g_v) + LUM_W'(2) * LUM_W'(b_v);
      luma_v = wsum_v[LUM_W-1:4];
      case (mode)
         2'b00:   res_v = {avg_v, avg_v, avg_v};
         2'b01:   res_v = {luma_v, luma_v, luma_v};
         2'b10:   res_v = (avg_v >= thr) ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
         2'b11:   res_v = ~pix;
         default: res_v = {PIX_W{1'b0}};
      endcase
      return res_v;
   endfunction

   logic [1:0]        state_r;
   logic [1:0]        state_nxt_s;
   logic              busy_r;
   logic              done_r;
   logic [1:0]        mode_r;
   logic [CH_W-1:0]   thresh_r;
   logic [ADDR_W-1:0] rd_addr_r;
   logic              start_s;
   logic              run_s;
   logic              last_rd_s;

   logic [RD_LAT-1:0] vld_pipe_r;
   logic [ADDR_W-1:0] addr_pipe_r [RD_LAT];

   logic              we_r;
   logic [ADDR_W-1:0] wr_addr_r;
   logic [PIX_W-1:0]  dout_r;

   // Decode of the current state used by the counter and pipeline.
   always_comb begin
      start_s   = (state_r == ST_IDLE) && enable_filter;
      run_s     = (state_r == ST_RUN);
      last_rd_s = (rd_addr_r == LAST_ADDR);
   end

   // Next-state logic; DRAIN ends once the final write is on the outputs.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (enable_filter) state_nxt_s = ST_RUN;
            else               state_nxt_s = ST_IDLE;
         end
         ST_RUN: begin
            if (last_rd_s) state_nxt_s = ST_DRAIN;
            else           state_nxt_s = ST_RUN;
         end
         ST_DRAIN: begin
            if (we_r && (wr_addr_r == LAST_ADDR)) state_nxt_s = ST_DONE;
            else                                  state_nxt_s = ST_DRAIN;
         end
         ST_DONE: begin
            if (!enable_filter) state_nxt_s = ST_IDLE;
            else                state_nxt_s = ST_DONE;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State, status flags, start-time configuration capture and read counter.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r   <= ST_IDLE;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         mode_r    <= 2'b00;
         thresh_r  <= {CH_W{1'b0}};
         rd_addr_r <= {ADDR_W{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         busy_r  <= (state_nxt_s == ST_RUN) || (state_nxt_s == ST_DRAIN);
         done_r  <= (state_nxt_s == ST_DONE);
         if (start_s) begin
            mode_r    <= mode_i;
            thresh_r  <= thresh_i;
            rd_addr_r <= {ADDR_W{1'b0}};
         end else if (run_s && !last_rd_s) begin
            rd_addr_r <= rd_addr_r + ADDR_W'(1);
         end
      end
   end

   // Delay line aligning each issued address with its returning read data.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         vld_pipe_r <= {RD_LAT{1'b0}};
         for (int i = 0; i < RD_LAT; i++) addr_pipe_r[i] <= {ADDR_W{1'b0}};
      end else begin
         vld_pipe_r[0]  <= run_s;
         addr_pipe_r[0] <= rd_addr_r;
         for (int i = 1; i < RD_LAT; i++) begin
            vld_pipe_r[i]  <= vld_pipe_r[i-1];
            addr_pipe_r[i] <= addr_pipe_r[i-1];
         end
      end
   end

   // Registered write port; address and data hold between writes.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         we_r      <= 1'b0;
         wr_addr_r <= {ADDR_W{1'b0}};
         dout_r    <= {PIX_W{1'b0}};
      end else begin
         we_r <= vld_pipe_r[RD_LAT-1];
         if (start_s) begin
            wr_addr_r <= {ADDR_W{1'b0}};
         end else if (vld_pipe_r[RD_LAT-1]) begin
            wr_addr_r <= addr_pipe_r[RD_LAT-1];
            dout_r    <= filter_pixel(mode_r, thresh_r, din_buf2);
         end
      end
   end

   assign busy_o      = busy_r;
   assign led_done    = done_r;
   assign rdaddr_buf2 = rd_addr_r;
   assign wraddr_buf2 = wr_addr_r;
   assign dout_buf2   = dout_r;
   assign we_buf2     = we_r;

endmodule
